// File: rtl/instr_cache_dm.sv
// Direct-mapped instruction cache: one-cycle hits, stalling line refill over a
// word-per-beat req/ack bus, and a global invalidate for code reload.
module instr_cache_dm #(
    parameter int INSTR_SIZE  = 32,
    parameter int N           = 32,
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_enable,
    input  logic [N-1:0]          PC,
    input  logic                  invalidate,
    output logic [INSTR_SIZE-1:0] instr,
    output logic                  instr_valid,
    output logic                  stall,
    output logic                  mem_req,
    output logic [N-1:0]          mem_addr,
    input  logic                  mem_ack,
    input  logic [INSTR_SIZE-1:0] mem_data
);

    localparam int TAG_BITS = N - 2 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 2 ** INDEX_BITS;
    localparam int WORDS    = 2 ** (INDEX_BITS + OFFSET_BITS);

    localparam logic [0:0] STATE_IDLE   = 1'b0;
    localparam logic [0:0] STATE_REFILL = 1'b1;

    logic [INSTR_SIZE-1:0]  data_mem [WORDS];
    logic [TAG_BITS-1:0]    tag_mem  [LINES];
    logic [LINES-1:0]       valid;
    logic [0:0]             state;
    logic [OFFSET_BITS-1:0] cnt;
    logic [OFFSET_BITS-1:0] cnt_next;
    logic                   drop;

    logic [TAG_BITS-1:0]    pc_tag;
    logic [INDEX_BITS-1:0]  pc_idx;
    logic [OFFSET_BITS-1:0] pc_off;
    logic [TAG_BITS-1:0]    ref_tag;
    logic [INDEX_BITS-1:0]  ref_idx;
    logic                   pc_byte_unused;

    logic hit;
    logic lookup;
    logic start_refill;
    logic beat;
    logic last_beat;

    assign pc_off         = PC[OFFSET_BITS+1:2];
    assign pc_idx         = PC[OFFSET_BITS+2 +: INDEX_BITS];
    assign pc_tag         = PC[N-1 -: TAG_BITS];
    assign pc_byte_unused = ^PC[1:0];

    // The line being refilled is identified by the upper bits of mem_addr,
    // which stay fixed for the whole refill.
    assign ref_tag = mem_addr[N-1 -: TAG_BITS];
    assign ref_idx = mem_addr[OFFSET_BITS+2 +: INDEX_BITS];

    assign hit          = valid[pc_idx] & (tag_mem[pc_idx] == pc_tag);
    assign lookup       = (state == STATE_IDLE) & read_enable & ~invalidate;
    assign start_refill = lookup & ~hit;
    assign beat         = (state == STATE_REFILL) & mem_req & mem_ack;
    assign last_beat    = beat & (&cnt);
    assign cnt_next     = cnt + OFFSET_BITS'(1);

    assign stall = (state == STATE_REFILL) | start_refill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STATE_IDLE;
            valid       <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            cnt         <= '0;
            drop        <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            if (invalidate) begin
                valid <= '0;
            end
            case (state)
                STATE_IDLE: begin
                    if (lookup && hit) begin
                        instr       <= data_mem[{pc_idx, pc_off}];
                        instr_valid <= 1'b1;
                    end else if (start_refill) begin
                        state    <= STATE_REFILL;
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= {pc_tag, pc_idx, {OFFSET_BITS{1'b0}}, 2'b00};
                    end
                end
                default: begin
                    if (invalidate) begin
                        drop <= 1'b1;
                    end
                    if (beat) begin
                        // Offset wraps to zero on the last beat, so mem_addr
                        // returns to the line base instead of leaving the line.
                        cnt      <= cnt_next;
                        mem_addr <= {ref_tag, ref_idx, cnt_next, 2'b00};
                    end
                    if (last_beat) begin
                        state   <= STATE_IDLE;
                        mem_req <= 1'b0;
                        drop    <= 1'b0;
                        if (!drop && !invalidate) begin
                            valid[ref_idx] <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: data and tag arrays carry no reset; the valid vector alone decides
    // whether their contents mean anything, which keeps them RAM-inferable.
    always_ff @(posedge clk) begin
        if (beat && !rst) begin
            data_mem[{ref_idx, cnt}] <= mem_data;
            if (&cnt) begin
                tag_mem[ref_idx] <= ref_tag;
            end
        end
    end

endmodule

// File: tb/tb_instr_cache_dm.sv
// Self-checking bench for instr_cache_dm: directed scenarios plus random
// fetches scored against a line-level cache model and a backing memory.
module tb_instr_cache_dm;

    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_enable;
    logic [31:0] PC;
    logic        invalidate;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    int checks   = 0;
    int failures = 0;
    int wait_n   = 1;

    logic [31:0] beat_q[$];
    bit          model_valid[LINES];
    logic [23:0] model_tag[LINES];

    instr_cache_dm dut (
        .clk        (clk),
        .rst        (rst),
        .read_enable(read_enable),
        .PC         (PC),
        .invalidate (invalidate),
        .instr      (instr),
        .instr_valid(instr_valid),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] backing(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'he3a0000a;
            32'h0000_0004: return 32'he3a00000;
            32'h0000_0008: return 32'he3a01001;
            32'h0000_000c: return 32'he0913002;
            default:       return (a * 32'h9e3779b1) ^ 32'h5a5a1234;
        endcase
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
    endfunction

    // Backing memory: acks every wait_n-th cycle of a request, checks that the
    // request is held while unacked, and throws garbage acks while idle.
    initial begin
        int          req_cycles;
        bit          prev_wait;
        logic [31:0] prev_addr;
        req_cycles = 0;
        prev_wait  = 1'b0;
        prev_addr  = '0;
        mem_ack    = 1'b0;
        mem_data   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1) begin
                if (prev_wait) begin
                    checks++;
                    if (mem_addr !== prev_addr) begin
                        failures++;
                        $display("FAIL addr_hold: mem_addr=%h expected=%h", mem_addr, prev_addr);
                    end
                end
                mem_ack  = ((req_cycles % wait_n) == wait_n - 1);
                mem_data = backing(mem_addr);
                if (mem_ack) beat_q.push_back(mem_addr);
                prev_wait  = !mem_ack;
                prev_addr  = mem_addr;
                req_cycles++;
            end else begin
                mem_ack    = 1'($urandom_range(0, 1));
                mem_data   = $urandom;
                req_cycles = 0;
                prev_wait  = 1'b0;
            end
        end
    end

    // Present pc until stall drops, then check the returned word, the stall
    // length and the refill beat addresses against the model.
    task automatic fetch(input logic [31:0] pc);
        int          idx;
        logic [23:0] tag;
        bit          exp_hit;
        int          exp_stall;
        int          n;
        logic [31:0] base;
        idx       = int'(pc[7:4]);
        tag       = pc[31:8];
        base      = {pc[31:4], 4'h0};
        exp_hit   = model_valid[idx] && (model_tag[idx] == tag);
        exp_stall = exp_hit ? 0 : 1 + WORDS * wait_n;
        n         = 0;
        beat_q.delete();
        PC          = pc;
        read_enable = 1'b1;
        invalidate  = 1'b0;
        #1;
        while (stall && n < 200) begin
            n++;
            @(posedge clk);
            #2;
        end
        checks++;
        if (n != exp_stall) begin
            failures++;
            $display("FAIL stall_cycles pc=%h: got=%0d expected=%0d", pc, n, exp_stall);
        end
        checks++;
        if (beat_q.size() != (exp_hit ? 0 : WORDS)) begin
            failures++;
            $display("FAIL beat_count pc=%h: got=%0d expected=%0d", pc, beat_q.size(),
                     exp_hit ? 0 : WORDS);
        end else begin
            for (int i = 0; i < beat_q.size(); i++) begin
                checks++;
                if (beat_q[i] !== base + 32'(4 * i)) begin
                    failures++;
                    $display("FAIL beat_addr pc=%h beat %0d: got=%h expected=%h", pc, i,
                             beat_q[i], base + 32'(4 * i));
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instr !== backing({pc[31:2], 2'b00})) begin
            failures++;
            $display("FAIL fetch_data pc=%h: got valid=%b instr=%h expected valid=1 instr=%h",
                     pc, instr_valid, instr, backing({pc[31:2], 2'b00}));
        end
        model_valid[idx] = 1'b1;
        model_tag[idx]   = tag;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        read_enable = 1'b0;
        invalidate  = 1'b0;
        PC          = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_instr: got instr=%h valid=%b expected 0/0", instr, instr_valid);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem: got req=%b addr=%h expected 0/0", mem_req, mem_addr);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got=%b expected=0", stall);
        end
        model_clear();
    endtask

    task automatic test_cold_miss();
        wait_n = 1;
        fetch(32'h0000_0000);
    endtask

    task automatic test_hits();
        fetch(32'h0000_0004);
        fetch(32'h0000_0008);
        fetch(32'h0000_000c);
        read_enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'he0913002) begin
            failures++;
            $display("FAIL idle_hold: got valid=%b instr=%h expected valid=0 instr=e0913002",
                     instr_valid, instr);
        end
    endtask

    task automatic test_conflict();
        fetch(32'h0000_0100);
        fetch(32'h0000_0000);
    endtask

    task automatic test_wait_states();
        wait_n = 3;
        fetch(32'h0000_0030);
        wait_n = 1;
        fetch(32'h0000_0034);
        fetch(32'h0000_0038);
        fetch(32'h0000_003c);
    endtask

    task automatic test_invalidate_idle();
        fetch(32'h0000_0004);
        PC          = 32'h0000_0008;
        read_enable = 1'b1;
        invalidate  = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL inv_idle_stall: got=%b expected=0", stall);
        end
        @(posedge clk);
        #1;
        invalidate = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL inv_idle_valid: got=%b expected=0", instr_valid);
        end
        model_clear();
        fetch(32'h0000_0008);
    endtask

    task automatic test_invalidate_mid_refill();
        int n;
        wait_n = 1;
        beat_q.delete();
        PC          = 32'h0000_0020;
        read_enable = 1'b1;
        invalidate  = 1'b0;
        n           = 0;
        #1;
        while (stall && n < 200) begin
            n++;
            @(posedge clk);
            #1;
            invalidate = (n == 2);
            #1;
        end
        invalidate = 1'b0;
        checks++;
        if (n != 2 * (WORDS + 1)) begin
            failures++;
            $display("FAIL inv_refill_stall: got=%0d expected=%0d", n, 2 * (WORDS + 1));
        end
        checks++;
        if (beat_q.size() != 2 * WORDS) begin
            failures++;
            $display("FAIL inv_refill_beats: got=%0d expected=%0d", beat_q.size(), 2 * WORDS);
        end else begin
            for (int i = 0; i < 2 * WORDS; i++) begin
                checks++;
                if (beat_q[i] !== 32'h20 + 32'(4 * (i % WORDS))) begin
                    failures++;
                    $display("FAIL inv_refill_addr beat %0d: got=%h expected=%h", i, beat_q[i],
                             32'h20 + 32'(4 * (i % WORDS)));
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (instr_valid !== 1'b1 || instr !== backing(32'h20)) begin
            failures++;
            $display("FAIL inv_refill_data: got valid=%b instr=%h expected valid=1 instr=%h",
                     instr_valid, instr, backing(32'h20));
        end
        model_clear();
        model_valid[2] = 1'b1;
        model_tag[2]   = 24'h0;
    endtask

    task automatic test_reset_mid_refill();
        PC          = 32'h0000_0040;
        read_enable = 1'b1;
        invalidate  = 1'b0;
        @(posedge clk);
        #1;
        rst         = 1'b1;
        read_enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_refill: got req=%b valid=%b stall=%b expected 0/0/0",
                     mem_req, instr_valid, stall);
        end
        model_clear();
        fetch(32'h0000_0040);
        fetch(32'h0000_0020);
    endtask

    task automatic test_random();
        logic [23:0] tags[4];
        logic [31:0] pc;
        tags[0] = 24'h000000;
        tags[1] = 24'h000001;
        tags[2] = 24'h00a5c3;
        tags[3] = 24'hffffff;
        for (int i = 0; i < 40; i++) begin
            wait_n = $urandom_range(1, 3);
            pc = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            fetch(pc);
        end
        wait_n      = 1;
        read_enable = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hits();
        test_conflict();
        test_wait_states();
        test_invalidate_idle();
        test_invalidate_mid_refill();
        test_reset_mid_refill();
        test_random();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_cache_dm.md
# instr_cache_dm

Parametrised direct-mapped instruction cache between the core's fetch stage (PC/instr) and a slower backing instruction memory. It serves hits with one-cycle latency. On a miss it stalls fetch and refills a whole line over a word-per-beat req/ack handshake. It also supports a global invalidate for code reload. It generalises the fixed 256-word instruction store into a configurable-geometry cache with miss handling.

## Interface
- INSTR_SIZE, 32: instruction/data word width.
- N, 32: PC and memory address width.
- INDEX_BITS, 4: log2 of the number of lines (default 16).
- OFFSET_BITS, 2: log2 of words per line (default 4). Tag width is N-2-INDEX_BITS-OFFSET_BITS.

- clk  in  1  clock. One clock domain; all state updates on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- read_enable  in  1  fetch request for PC this cycle.
- PC  in  N  byte address. Bits [1:0] are ignored; word offset is PC[OFFSET_BITS+1:2]; index is the next INDEX_BITS bits; tag is the rest.
- invalidate  in  1  clear all line valid bits.
- instr  out  INSTR_SIZE  fetched instruction (registered).
- instr_valid  out  1  instr holds a hit for the PC presented the previous cycle.
- stall  out  1  combinational; core must hold PC and read_enable while high.
- mem_req  out  1  refill beat request (registered).
- mem_addr  out  N  word-aligned refill address (registered).
- mem_ack  in  1  mem_data valid for the current beat.
- mem_data  in  INSTR_SIZE  refill word.

## Operation
- Storage: data array of 2^(INDEX_BITS+OFFSET_BITS) words, tag array of 2^INDEX_BITS entries, and a valid bit vector.
- FSM states:
  - IDLE to REFILL: on read_enable & miss & ~invalidate.
  - REFILL to IDLE: on the ack of the last beat, or on rst.
- hit = valid[idx] & (tag[idx] == PC tag).
- IDLE, read_enable & hit: instr <= word, instr_valid <= 1.
- IDLE, otherwise: instr_valid <= 0 and instr holds its value.
- IDLE miss: latch refill base = {PC tag, idx, 0 offset}. Beat counter = 0. mem_req <= 1, mem_addr <= base.
- REFILL: on each mem_ack, write mem_data into data[idx][cnt], increment cnt, mem_addr += 4.
  - On the ack with cnt == 2^OFFSET_BITS-1: mem_req <= 0, tag[idx] <= latched tag, valid[idx] <= 1 (unless dropped), go to IDLE.
  - mem_ack while mem_req is low is ignored.
- PC changes during REFILL are ignored; the latched address is used. After return to IDLE, the held PC is looked up again and hits.
- stall = (state == REFILL) | (state == IDLE & read_enable & ~hit & ~invalidate).
- invalidate in IDLE:
  - Clears all valid bits this edge.
  - Overrides the lookup: instr_valid <= 0 and no refill starts.
  - stall is 0 that cycle; the core re-presents PC.
- invalidate in REFILL:
  - Clears all valid bits and sets a drop flag.
  - The refill completes its remaining beats (no aborted bus transaction).
  - The filled line is left invalid and the drop flag clears on exit.
- Reset values: state IDLE, all valid 0, instr 0, instr_valid 0, mem_req 0, mem_addr 0, cnt 0, drop 0. Data and tag arrays are not reset.

## Timing
- Hit latency: PC/read_enable at edge k produces instr/instr_valid after edge k+1.
- Miss latency with zero-wait memory (mem_ack tied high):
  - Miss detected in cycle k; mem_req high from k+1.
  - 2^OFFSET_BITS beats; IDLE entered after the last-ack edge.
  - Re-lookup the next cycle. Total = 2^OFFSET_BITS + 2 cycles to instr_valid (6 at default).
- Wait states stretch beats; mem_req and mem_addr stay stable until acked.
- Simultaneous events:
  - rst beats everything, including mid-refill: mem_req drops at that edge.
  - invalidate beats lookup.
  - The last-beat ack and invalidate in the same cycle leave the line invalid.
- Wrap-around:
  - Beat counter wraps only at exit.
  - mem_addr never crosses a line boundary.
  - PC wrap at 2^N needs no special case.

## Test plan
- Cold miss: rst, then PC=0x00 read_enable=1, zero-wait memory returning e3a0000a, e3a00000, e3a01001, e0913002.
  - Expect mem_addr 0x00/0x04/0x08/0x0C and stall high for 5 cycles.
  - Then instr=e3a0000a with instr_valid=1.
- Hits: after the fill, PC 0x04, 0x08, 0x0C on consecutive cycles.
  - Expect instr e3a00000, e3a01001, e0913002, each one cycle later, with stall=0.
- Conflict eviction: fetch 0x100 (same index 0, new tag).
  - Expect refill at 0x100–0x10C.
  - A following fetch of 0x00 misses again.
- Wait states: mem_ack asserted every third cycle.
  - Expect mem_addr held per beat and the correct 4 words stored.
  - Refill completes in 12 cycles.
- Invalidate mid-refill: assert invalidate during beat 2 of a fill at 0x20.
  - Expect all 4 beats to complete, then a re-miss on 0x20 and a second refill.
- Reset mid-refill: rst during beat 1.
  - Expect mem_req=0, instr_valid=0, stall=0 next cycle.
  - A subsequent fetch of the same PC misses.
